// File: rtl/rbr_pkg.sv
// Shared types for the redundant-binary on-the-fly converter: the signed digit,
// the control FSM states and a digit decoder.
package rbr_pkg;

   typedef struct packed {
      logic plus;
      logic minus;
   } signed_digit;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      FULL  = 2'd2
   } otf_state_e;

   typedef enum logic [1:0] {
      D_ZERO  = 2'd0,
      D_PLUS  = 2'd1,
      D_MINUS = 2'd2
   } digit_kind_e;

   // {1,1} is a redundant encoding of zero, same as {0,0}
   function automatic digit_kind_e decode_digit(input signed_digit d);
      digit_kind_e k;
      if (d.plus && !d.minus) begin
         k = D_PLUS;
      end else if (!d.plus && d.minus) begin
         k = D_MINUS;
      end else begin
         k = D_ZERO;
      end
      return k;
   endfunction

endpackage

// File: rtl/otf_conv_lane.sv
// One lane of the on-the-fly converter: holds Q and QM and folds in one signed
// digit at the one-hot position supplied by the shared control path.
module otf_conv_lane
   import rbr_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  signed_digit      digit,
   input  logic [WIDTH-1:0] pos,
   input  logic             clr,
   input  logic             load,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qm,
   output logic [WIDTH-1:0] q_next,
   output logic [WIDTH-1:0] qm_next
);

   logic [WIDTH-1:0] base_q_s;
   logic [WIDTH-1:0] base_qm_s;

   // Next Q/QM; a clear in the same cycle makes the digit start from zero
   always_comb begin
      base_q_s  = clr ? {WIDTH{1'b0}} : q;
      base_qm_s = clr ? {WIDTH{1'b0}} : qm;
      q_next    = base_q_s;
      qm_next   = base_qm_s;
      case (decode_digit(digit))
         D_PLUS: begin
            q_next  = base_q_s | pos;
            qm_next = base_q_s;
         end
         D_MINUS: begin
            q_next  = base_qm_s | pos;
            qm_next = base_qm_s;
         end
         default: begin
            q_next  = base_q_s;
            qm_next = base_qm_s | pos;
         end
      endcase
   end

   // Accumulator registers
   always_ff @(posedge clk) begin
      if (rst) begin
         q  <= {WIDTH{1'b0}};
         qm <= {WIDTH{1'b0}};
      end else if (load) begin
         q  <= q_next;
         qm <= qm_next;
      end else if (clr) begin
         q  <= {WIDTH{1'b0}};
         qm <= {WIDTH{1'b0}};
      end else begin
         q  <= q;
         qm <= qm;
      end
   end

endmodule

// File: rtl/otf_conv_mc.sv
// Multi-lane on-the-fly converter: shared digit counter and frame FSM, a
// per-lane Q/QM accumulator, and a one-deep output buffer with backpressure.
module otf_conv_mc
   import rbr_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic                            en,
   input  signed_digit [CHANNELS-1:0]      x,
   output logic                            in_ready,
   output logic [CHANNELS-1:0][WIDTH-1:0]  q_out,
   output logic [CHANNELS-1:0][WIDTH-1:0]  qm_out,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic                            overrun
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_J = CW'(WIDTH - 1);

   otf_state_e                     state_r;
   logic [CW-1:0]                  j_r;
   logic [CW-1:0]                  j_eff_s;
   logic [WIDTH-1:0]               pos_s;
   logic                           clr_s;
   logic                           accept_s;
   logic                           last_s;
   logic                           buf_free_s;
   logic                           take_s;
   logic [CHANNELS-1:0][WIDTH-1:0] acc_q_s;
   logic [CHANNELS-1:0][WIDTH-1:0] acc_qm_s;
   logic [CHANNELS-1:0][WIDTH-1:0] nxt_q_s;
   logic [CHANNELS-1:0][WIDTH-1:0] nxt_qm_s;

   // Handshake decode; a start outside FULL restarts the frame at digit 0
   always_comb begin
      in_ready   = (state_r == ACCUM) || ((state_r == IDLE) && start);
      clr_s      = start && (state_r != FULL);
      accept_s   = en && in_ready;
      j_eff_s    = clr_s ? {CW{1'b0}} : j_r;
      pos_s      = {1'b1, {(WIDTH-1){1'b0}}} >> j_eff_s;
      last_s     = accept_s && (j_eff_s == LAST_J);
      buf_free_s = !out_valid || out_ready;
      take_s     = out_valid && out_ready;
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      otf_conv_lane #(.WIDTH(WIDTH)) u_lane (
         .clk     (clk),
         .rst     (rst),
         .digit   (x[c]),
         .pos     (pos_s),
         .clr     (clr_s),
         .load    (accept_s),
         .q       (acc_q_s[c]),
         .qm      (acc_qm_s[c]),
         .q_next  (nxt_q_s[c]),
         .qm_next (nxt_qm_s[c])
      );
   end

   // Frame FSM, digit counter, overrun flag and output buffer
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         j_r       <= {CW{1'b0}};
         overrun   <= 1'b0;
         out_valid <= 1'b0;
         q_out     <= {(CHANNELS*WIDTH){1'b0}};
         qm_out    <= {(CHANNELS*WIDTH){1'b0}};
      end else begin
         case (state_r)
            IDLE:    state_r <= start ? ACCUM : IDLE;
            ACCUM:   state_r <= last_s ? (buf_free_s ? IDLE : FULL) : ACCUM;
            FULL:    state_r <= take_s ? IDLE : FULL;
            default: state_r <= IDLE;
         endcase

         if (last_s) begin
            j_r <= {CW{1'b0}};
         end else if (accept_s) begin
            j_r <= j_eff_s + {{(CW-1){1'b0}}, 1'b1};
         end else if (clr_s) begin
            j_r <= {CW{1'b0}};
         end else begin
            j_r <= j_r;
         end

         if (clr_s) begin
            overrun <= 1'b0;
         end else if (en && !in_ready) begin
            overrun <= 1'b1;
         end else begin
            overrun <= overrun;
         end

         // A frame finishing into a free buffer bypasses the accumulator copy
         if (last_s && buf_free_s) begin
            q_out     <= nxt_q_s;
            qm_out    <= nxt_qm_s;
            out_valid <= 1'b1;
         end else if ((state_r == FULL) && take_s) begin
            q_out     <= acc_q_s;
            qm_out    <= acc_qm_s;
            out_valid <= 1'b1;
         end else if (take_s) begin
            out_valid <= 1'b0;
         end else begin
            out_valid <= out_valid;
         end
      end
   end

endmodule

// File: tb/tb_otf_conv_mc.sv
// Bench for otf_conv_mc (WIDTH=8, CHANNELS=2): directed frames plus random traffic,
// checked every cycle against an integer-sum model of the conversion and buffer.
module tb_otf_conv_mc;
   import rbr_pkg::*;

   localparam int W = 8;
   localparam int C = 2;
   localparam logic [1:0] P = 2'b10;
   localparam logic [1:0] M = 2'b01;
   localparam logic [1:0] Z = 2'b00;
   localparam logic [15:0] F036  = 16'b10_00_01_00_00_00_00_10;
   localparam logic [15:0] ALL_P = 16'hAAAA;
   localparam logic [15:0] ALL_M = 16'h5555;
   localparam logic [15:0] ALL_B = 16'hFFFF;
   localparam logic [15:0] ALL_Z = 16'h0000;

   logic clk = 1'b0;
   logic rst, start, en, out_ready;
   logic in_ready, out_valid, overrun;
   signed_digit [C-1:0] x;
   logic [C-1:0][W-1:0] q_out, qm_out;

   int checks = 0;
   int errors = 0;
   bit live = 1'b0;

   // model: frames as integer digit sums, buffer as plain values
   bit m_active, m_full, m_valid, m_ov;
   int m_j;
   int m_sum [C];
   int m_pend [C];
   logic [7:0] m_q [C];
   logic [7:0] m_qm [C];

   always #5 clk = ~clk;

   otf_conv_mc #(.WIDTH(W), .CHANNELS(C)) dut (
      .clk(clk), .rst(rst), .start(start), .en(en), .x(x),
      .in_ready(in_ready), .q_out(q_out), .qm_out(qm_out),
      .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int dval(input logic [1:0] d);
      return (d == 2'b10) ? 1 : ((d == 2'b01) ? -1 : 0);
   endfunction

   function automatic logic [7:0] mod256(input int s);
      return 8'(((s % 256) + 256) % 256);
   endfunction

   task automatic load_buf(input int v0, input int v1);
      m_q[0]  = mod256(v0);
      m_qm[0] = mod256(v0 - 1);
      m_q[1]  = mod256(v1);
      m_qm[1] = mod256(v1 - 1);
   endtask

   // advance the model by one clock edge using the inputs that were applied
   task automatic model_step();
      bit ir, take, free, done;
      if (rst) begin
         m_active = 0; m_full = 0; m_valid = 0; m_ov = 0; m_j = 0;
         for (int c = 0; c < C; c++) begin
            m_sum[c] = 0; m_q[c] = 8'h00; m_qm[c] = 8'h00;
         end
         return;
      end
      ir   = m_active || (!m_full && start);
      take = m_valid && out_ready;
      free = !m_valid || out_ready;
      done = 0;
      if (en && !ir) m_ov = 1;
      if (start && !m_full) begin
         m_active = 1; m_j = 0; m_ov = 0;
         for (int c = 0; c < C; c++) m_sum[c] = 0;
      end
      if (en && ir) begin
         for (int c = 0; c < C; c++)
            m_sum[c] += dval({x[c].plus, x[c].minus}) * (1 << (W - 1 - m_j));
         m_j++;
         if (m_j == W) begin
            done = 1;
            m_active = 0;
         end
      end
      if (done && free) begin
         load_buf(m_sum[0], m_sum[1]);
         m_valid = 1;
      end else if (done) begin
         m_full = 1;
         m_pend[0] = m_sum[0];
         m_pend[1] = m_sum[1];
      end else if (m_full && take) begin
         load_buf(m_pend[0], m_pend[1]);
         m_full = 0;
      end else if (take) begin
         m_valid = 0;
      end
   endtask

   task automatic cyc(input logic r, input logic s, input logic e,
                      input logic [1:0] d0, input logic [1:0] d1, input logic ordy);
      rst = r; start = s; en = e; x = {d1, d0}; out_ready = ordy;
      @(posedge clk);
      #1;
      model_step();
      live = 1'b1;
   endtask

   task automatic send(input logic [15:0] s0, input logic [15:0] s1, input int first,
                       input int last, input logic ordy);
      for (int j = first; j <= last; j++)
         cyc(1'b0, 1'b0, 1'b1, s0[15-2*j -: 2], s1[15-2*j -: 2], ordy);
   endtask

   task automatic pin(input string name, input int c, input logic [7:0] q, input logic [7:0] qm);
      chk({name, "_q"}, 32'(q_out[c]), 32'(q));
      chk({name, "_qm"}, 32'(qm_out[c]), 32'(qm));
   endtask

   // per-cycle comparison against the model
   always @(negedge clk) begin
      if (live) begin
         chk("in_ready", 32'(in_ready), 32'(m_active || (!m_full && start)));
         chk("out_valid", 32'(out_valid), 32'(m_valid));
         chk("overrun", 32'(overrun), 32'(m_ov));
         for (int c = 0; c < C; c++) begin
            chk("q_out", 32'(q_out[c]), 32'(m_q[c]));
            chk("qm_out", 32'(qm_out[c]), 32'(m_qm[c]));
         end
      end
   end

   initial begin
      rst = 1'b1; start = 1'b0; en = 1'b0; x = 4'b0000; out_ready = 1'b0;
      cyc(1'b1, 1'b0, 1'b0, Z, Z, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, Z, Z, 1'b0);
      chk("reset_valid", 32'(out_valid), 32'd0);
      chk("reset_ready", 32'(in_ready), 32'd0);
      pin("reset", 0, 8'h00, 8'h00);

      // basic conversion, latency of out_valid
      cyc(1'b0, 1'b1, 1'b0, Z, Z, 1'b0);
      send(F036, ALL_M, 0, 6, 1'b0);
      chk("pre_last_valid", 32'(out_valid), 32'd0);
      send(F036, ALL_M, 7, 7, 1'b0);
      chk("conv_valid", 32'(out_valid), 32'd1);
      pin("conv_l0", 0, 8'h61, 8'h60);
      pin("conv_l1", 1, 8'h01, 8'h00);
      cyc(1'b0, 1'b0, 1'b0, Z, Z, 1'b1);
      chk("drain_valid", 32'(out_valid), 32'd0);

      // zero digits in both encodings
      cyc(1'b0, 1'b1, 1'b0, Z, Z, 1'b1);
      send(ALL_Z, ALL_B, 0, 7, 1'b1);
      pin("zero_l0", 0, 8'h00, 8'hFF);
      pin("zero_l1", 1, 8'h00, 8'hFF);
      cyc(1'b0, 1'b0, 1'b0, Z, Z, 1'b1);

      // backpressure: A buffered, B held in FULL
      cyc(1'b0, 1'b1, 1'b0, Z, Z, 1'b0);
      send(ALL_P, ALL_Z, 0, 7, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, Z, Z, 1'b0);
      send(F036, ALL_M, 0, 7, 1'b0);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      cyc(1'b0, 1'b0, 1'b1, P, P, 1'b0);
      chk("full_overrun", 32'(overrun), 32'd1);
      pin("bp_a_l0", 0, 8'hFF, 8'hFE);
      pin("bp_a_l1", 1, 8'h00, 8'hFF);
      cyc(1'b0, 1'b0, 1'b0, Z, Z, 1'b1);
      chk("bp_b_valid", 32'(out_valid), 32'd1);
      pin("bp_b_l0", 0, 8'h61, 8'h60);
      pin("bp_b_l1", 1, 8'h01, 8'h00);
      cyc(1'b0, 1'b0, 1'b0, Z, Z, 1'b1);
      chk("bp_drain_valid", 32'(out_valid), 32'd0);

      // abort after three digits
      cyc(1'b0, 1'b1, 1'b0, Z, Z, 1'b1);
      send(ALL_P, ALL_P, 0, 2, 1'b1);
      cyc(1'b0, 1'b1, 1'b0, Z, Z, 1'b1);
      chk("abort_overrun", 32'(overrun), 32'd0);
      send(F036, ALL_Z, 0, 7, 1'b1);
      pin("abort_l0", 0, 8'h61, 8'h60);
      pin("abort_l1", 1, 8'h00, 8'hFF);
      cyc(1'b0, 1'b0, 1'b0, Z, Z, 1'b1);

      // start and first digit together
      cyc(1'b0, 1'b1, 1'b1, P, Z, 1'b1);
      send(F036, ALL_Z, 1, 7, 1'b1);
      chk("same_valid", 32'(out_valid), 32'd1);
      pin("same_l0", 0, 8'h61, 8'h60);
      cyc(1'b0, 1'b0, 1'b0, Z, Z, 1'b1);

      // reset mid-frame, then while a frame is buffered with overrun set
      cyc(1'b0, 1'b1, 1'b0, Z, Z, 1'b0);
      send(ALL_P, ALL_M, 0, 3, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, Z, Z, 1'b0);
      chk("rst1_valid", 32'(out_valid), 32'd0);
      chk("rst1_ready", 32'(in_ready), 32'd0);
      chk("rst1_overrun", 32'(overrun), 32'd0);
      pin("rst1", 0, 8'h00, 8'h00);
      cyc(1'b0, 1'b1, 1'b0, Z, Z, 1'b0);
      send(ALL_P, ALL_M, 0, 7, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, Z, Z, 1'b0);
      chk("pre_rst2_valid", 32'(out_valid), 32'd1);
      chk("pre_rst2_overrun", 32'(overrun), 32'd1);
      cyc(1'b1, 1'b0, 1'b0, Z, Z, 1'b0);
      chk("rst2_valid", 32'(out_valid), 32'd0);
      chk("rst2_ready", 32'(in_ready), 32'd0);
      chk("rst2_overrun", 32'(overrun), 32'd0);
      pin("rst2_l0", 0, 8'h00, 8'h00);
      pin("rst2_l1", 1, 8'h00, 8'h00);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         cyc(1'($urandom_range(199) == 0), 1'($urandom_range(11) == 0),
             1'($urandom_range(3) != 0), 2'($urandom_range(3)), 2'($urandom_range(3)),
             1'($urandom_range(1)));
      end
      cyc(1'b0, 1'b0, 1'b0, Z, Z, 1'b1);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
